updown_mod_counter: RTL and testbench

Parametrised synchronous up/down counter. It generalises the team's 3-bit T-flip-flop up/down counter to arbitrary width and modulus, and adds parallel load, a wrap/saturate mode, a terminal-count output, a registered wrap pulse and a sticky overflow flag. It is used as a general-purpose event/position counter: timers, address generators and BCD-style digit chains, where digits are cascaded via tc and en.

---
 rtl/updown_mod_counter_if.sv | 32 +++
 rtl/updown_mod_counter.sv | 76 +++++++
 tb/tb_updown_mod_counter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/updown_mod_counter_if.sv
// updown_mod_counter_if
// Groups the control inputs and status outputs of updown_mod_counter.
//   en      count enable          down    direction (1 = down)
//   sat     saturate mode         load    parallel load strobe
//   din     load value            clr_ovf clear sticky overflow
//   q       current count         tc      terminal count (combinational)
//   wrap    registered wrap pulse ovf     sticky overflow flag
// master drives the controls; slave is the counter itself.
interface updown_mod_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             down;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             clr_ovf;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, down, sat, load, din, clr_ovf,
        input  q, tc, wrap, ovf
    );

    modport slave (
        input  en, down, sat, load, din, clr_ovf,
        output q, tc, wrap, ovf
    );
endinterface

// File: rtl/updown_mod_counter.sv
// updown_mod_counter
// Parametrised synchronous up/down counter over 0..MAX with parallel load,
// wrap/saturate mode, terminal count, registered wrap pulse and sticky
// overflow flag. Digits cascade by feeding one counter's tc into the next
// counter's en.
//   clk  : rising-edge clock
//   nrst : synchronous active-low reset
//   bus  : control/status bundle (slave side), see updown_mod_counter_if
module updown_mod_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = (2**WIDTH) - 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    updown_mod_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic             ovf_r;

    // Boundary tests are done on q before any arithmetic so the
    // increment never needs a carry bit beyond WIDTH.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            wrap_r <= 1'b0;
            if (bus.clr_ovf) begin
                ovf_r <= 1'b0;
            end
            if (bus.load) begin
                q_r <= (bus.din > MAXV) ? MAXV : bus.din;
            end else if (bus.en) begin
                if (!bus.down) begin
                    if (q_r < MAXV) begin
                        q_r <= q_r + 1'b1;
                    end else begin
                        // Covers q==MAX and the unreachable q>MAX case.
                        // Assigned after the clear so a set event wins.
                        ovf_r <= 1'b1;
                        if (bus.sat) begin
                            q_r <= MAXV;
                        end else begin
                            q_r    <= '0;
                            wrap_r <= 1'b1;
                        end
                    end
                end else begin
                    if (q_r == '0) begin
                        ovf_r <= 1'b1;
                        if (!bus.sat) begin
                            q_r    <= MAXV;
                            wrap_r <= 1'b1;
                        end
                    end else if (q_r > MAXV) begin
                        q_r <= MAXV;
                    end else begin
                        q_r <= q_r - 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.q    = q_r;
        bus.wrap = wrap_r;
        bus.ovf  = ovf_r;
        bus.tc   = bus.en & ((~bus.down & (q_r == MAXV)) |
                             ( bus.down & (q_r == '0)));
    end
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter
// Scoreboard bench: the stimulus process drives inputs on the falling edge
// and pushes the expected post-edge state computed by an arithmetic model;
// monitor processes pop and compare after each rising edge. A second pair
// of counters is cascaded as a two-digit decimal counter.
module tb_updown_mod_counter;
    localparam int MAX = 9;

    typedef struct {
        int q;
        bit wrap;
        bit ovf;
        bit tc;
    } exp_t;

    typedef struct {
        int val;
        bit hwrap;
    } cexp_t;

    logic clk = 1'b0;
    logic nrst;
    logic nrst_c;

    int checks = 0;
    int errors = 0;

    exp_t  sb[$];
    cexp_t csb[$];

    // model state
    int m_q    = 0;
    bit m_wrap = 0;
    bit m_ovf  = 0;

    always #5 clk = ~clk;

    updown_mod_counter_if #(.WIDTH(4)) m_if ();
    updown_mod_counter_if #(.WIDTH(4)) lo_if ();
    updown_mod_counter_if #(.WIDTH(4)) hi_if ();

    updown_mod_counter #(.WIDTH(4), .MAX(MAX)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (m_if)
    );

    updown_mod_counter #(.WIDTH(4), .MAX(MAX)) u_lo (
        .clk  (clk),
        .nrst (nrst_c),
        .bus  (lo_if)
    );

    updown_mod_counter #(.WIDTH(4), .MAX(MAX)) u_hi (
        .clk  (clk),
        .nrst (nrst_c),
        .bus  (hi_if)
    );

    assign hi_if.en = lo_if.tc;

    task automatic step(input bit rn, input bit e, input bit d, input bit s,
                        input bit l, input int di, input bit c);
        int nxt;
        exp_t x;
        @(negedge clk);
        nrst         = rn;
        m_if.en      = e;
        m_if.down    = d;
        m_if.sat     = s;
        m_if.load    = l;
        m_if.din     = 4'(di);
        m_if.clr_ovf = c;
        if (!rn) begin
            m_q = 0; m_wrap = 0; m_ovf = 0;
        end else begin
            m_wrap = 0;
            if (c) m_ovf = 0;
            if (l) begin
                m_q = (di > MAX) ? MAX : di;
            end else if (e) begin
                nxt = d ? m_q - 1 : m_q + 1;
                if (nxt < 0 || nxt > MAX) begin
                    m_ovf = 1;
                    if (s) begin
                        m_q = (nxt < 0) ? 0 : MAX;
                    end else begin
                        m_q    = (nxt + MAX + 1) % (MAX + 1);
                        m_wrap = 1;
                    end
                end else begin
                    m_q = nxt;
                end
            end
        end
        x.q    = m_q;
        x.wrap = m_wrap;
        x.ovf  = m_ovf;
        x.tc   = e && ((!d && m_q == MAX) || (d && m_q == 0));
        sb.push_back(x);
    endtask

    // main monitor
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if (int'(m_if.q) != x.q) begin
                    errors++;
                    $display("FAIL q t=%0t got %0d exp %0d", $time, m_if.q, x.q);
                end
                checks++;
                if (m_if.wrap !== x.wrap) begin
                    errors++;
                    $display("FAIL wrap t=%0t got %b exp %b", $time, m_if.wrap, x.wrap);
                end
                checks++;
                if (m_if.ovf !== x.ovf) begin
                    errors++;
                    $display("FAIL ovf t=%0t got %b exp %b", $time, m_if.ovf, x.ovf);
                end
                checks++;
                if (m_if.tc !== x.tc) begin
                    errors++;
                    $display("FAIL tc t=%0t got %b exp %b", $time, m_if.tc, x.tc);
                end
            end
        end
    end

    // cascade monitor
    initial begin
        cexp_t y;
        int v;
        forever begin
            @(posedge clk);
            #1;
            if (csb.size() > 0) begin
                y = csb.pop_front();
                v = int'(hi_if.q) * 10 + int'(lo_if.q);
                checks++;
                if (v != y.val) begin
                    errors++;
                    $display("FAIL cascade_val t=%0t got %0d exp %0d", $time, v, y.val);
                end
                checks++;
                if (hi_if.wrap !== y.hwrap) begin
                    errors++;
                    $display("FAIL cascade_hwrap t=%0t got %b exp %b", $time, hi_if.wrap, y.hwrap);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        cexp_t y;
        nrst_c        = 1'b0;
        lo_if.en      = 1'b0;
        lo_if.down    = 1'b0;
        lo_if.sat     = 1'b0;
        lo_if.load    = 1'b0;
        lo_if.din     = '0;
        lo_if.clr_ovf = 1'b0;
        hi_if.down    = 1'b0;
        hi_if.sat     = 1'b0;
        hi_if.load    = 1'b0;
        hi_if.din     = '0;
        hi_if.clr_ovf = 1'b0;

        // reset overrides load/en; tc high while down
        step(0, 1, 1, 0, 1, 5, 0);
        step(0, 1, 1, 0, 1, 5, 0);
        // up wrap, 12 counts
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0, 0, 0);
        // down saturate
        step(1, 0, 0, 0, 1, 2, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0, 1);
        // load clamp and priority over en
        step(1, 1, 0, 0, 1, 14, 0);
        step(1, 1, 0, 0, 1, 3, 0);
        // simultaneous set/clear of ovf
        step(1, 0, 0, 0, 1, 9, 0);
        step(1, 1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) != 0,
                 $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 15)),
                 $urandom_range(0, 7) == 0);
        end

        // two-digit cascade: 100 counts from 00
        @(negedge clk);
        nrst_c = 1'b0;
        lo_if.en = 1'b0;
        y.val = 0; y.hwrap = 0;
        csb.push_back(y);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            nrst_c   = 1'b1;
            lo_if.en = 1'b1;
            y.val   = k % 100;
            y.hwrap = (k == 100);
            csb.push_back(y);
        end
        @(negedge clk);
        lo_if.en = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0 || csb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending exp 0", sb.size(), csb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
